// File: rtl/time_set_controller.sv
// time_set_controller: debounces the four KEY buttons and runs the hour/minute/second
// edit FSM that loads the clock counter. Optional hold-to-repeat: `TIME_SET_AUTOREPEAT_EN.
module time_set_controller #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_CYCLES   = 12500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] button,
    input  logic [4:0] hourIn,
    input  logic [5:0] minIn,
    input  logic [5:0] secIn,
    output logic       set,
    output logic       load,
    output logic [4:0] hourOut,
    output logic [5:0] minOut,
    output logic [5:0] secOut,
    output logic [1:0] sethms,
    output logic       upDown
);
    localparam logic [2:0] ST_RUN    = 3'd0;
    localparam logic [2:0] ST_EDIT_H = 3'd1;
    localparam logic [2:0] ST_EDIT_M = 3'd2;
    localparam logic [2:0] ST_EDIT_S = 3'd3;
    localparam logic [2:0] ST_COMMIT = 3'd4;

    localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    generate
        if (DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_param_check
            $error("time_set_controller: cycle parameters must be >= 1");
        end
    endgenerate

    logic [3:0] press;
`ifdef TIME_SET_AUTOREPEAT_EN
    logic [3:2] held;
`endif

    // Per button: pressed-high synchronizer, run-length debouncer, rising-edge pulse.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_btn
            logic            sync1_reg, sync2_reg, level_reg, press_reg;
            logic [DB_W-1:0] cnt_reg;
            logic            differ, flip;

            assign differ = sync2_reg ^ level_reg;
            assign flip   = differ && (cnt_reg == DB_LAST);

            always_ff @(posedge clk) begin
                if (rst) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    level_reg <= 1'b0;
                    press_reg <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    sync1_reg <= ~button[gi];
                    sync2_reg <= sync1_reg;
                    cnt_reg   <= (differ && !flip) ? cnt_reg + 1'b1 : '0;
                    if (flip) level_reg <= sync2_reg;
                    press_reg <= flip & sync2_reg;
                end
            end

            assign press[gi] = press_reg;
`ifdef TIME_SET_AUTOREPEAT_EN
            if (gi >= 2) begin : g_held
                assign held[gi] = level_reg;
            end
`endif
        end
    endgenerate

    logic [2:0] state_reg, state_next;
    logic [4:0] hour_reg, hour_next;
    logic [5:0] min_reg, min_next, sec_reg, sec_next;
    logic       updown_reg, updown_next;
    logic       set_reg, load_reg;
    logic [1:0] sethms_reg;
    logic       mode_p, field_p, step_up, step_dn, editing;

    assign mode_p  = press[0];
    assign field_p = press[1];
    assign editing = (state_reg == ST_EDIT_H) || (state_reg == ST_EDIT_M) || (state_reg == ST_EDIT_S);

`ifdef TIME_SET_AUTOREPEAT_EN
    localparam int              RP_W    = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RP_W-1:0] RP_LAST = RP_W'(REPEAT_CYCLES - 1);

    logic [RP_W-1:0] rep_cnt_reg;
    logic            rep_fire, rep_clear;

    // Repeats only while exactly one of up/down is held and no fresh event arrives.
    assign rep_fire  = editing && (held[2] ^ held[3]) && !(|press) && (rep_cnt_reg == RP_LAST);
    assign rep_clear = !editing || !(held[2] ^ held[3]) || (|press) || rep_fire;

    always_ff @(posedge clk) begin
        if (rst || rep_clear) rep_cnt_reg <= '0;
        else                  rep_cnt_reg <= rep_cnt_reg + 1'b1;
    end

    assign step_up = rep_fire ? held[2] : (press[2] & ~press[3]);
    assign step_dn = rep_fire ? held[3] : (press[3] & ~press[2]);
`else
    assign step_up = press[2] & ~press[3];
    assign step_dn = press[3] & ~press[2];
`endif

    function automatic logic [5:0] wrap60(input logic [5:0] v, input logic up);
        if (up) return (v == 6'd59) ? 6'd0 : v + 6'd1;
        return (v == 6'd0) ? 6'd59 : v - 6'd1;
    endfunction

    always_comb begin
        state_next  = state_reg;
        hour_next   = hour_reg;
        min_next    = min_reg;
        sec_next    = sec_reg;
        updown_next = updown_reg;
        case (state_reg)
            ST_RUN: begin
                if (mode_p) begin
                    state_next = ST_EDIT_H;
                    hour_next  = (hourIn > 5'd23) ? 5'd0 : hourIn;
                    min_next   = (minIn > 6'd59) ? 6'd0 : minIn;
                    sec_next   = (secIn > 6'd59) ? 6'd0 : secIn;
                end
            end
            ST_EDIT_H, ST_EDIT_M, ST_EDIT_S: begin
                if (mode_p) begin
                    state_next = ST_COMMIT;
                end else if (field_p) begin
                    state_next = (state_reg == ST_EDIT_S) ? ST_EDIT_H : state_reg + 3'd1;
                end else if (step_up || step_dn) begin
                    updown_next = step_up;
                    case (state_reg)
                        ST_EDIT_H: hour_next = step_up ? ((hour_reg == 5'd23) ? 5'd0 : hour_reg + 5'd1)
                                                       : ((hour_reg == 5'd0) ? 5'd23 : hour_reg - 5'd1);
                        ST_EDIT_M: min_next  = wrap60(min_reg, step_up);
                        default:   sec_next  = wrap60(sec_reg, step_up);
                    endcase
                end
            end
            default: state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_RUN;
            hour_reg   <= '0;
            min_reg    <= '0;
            sec_reg    <= '0;
            updown_reg <= 1'b1;
            set_reg    <= 1'b0;
            load_reg   <= 1'b0;
            sethms_reg <= 2'd0;
        end else begin
            state_reg  <= state_next;
            hour_reg   <= hour_next;
            min_reg    <= min_next;
            sec_reg    <= sec_next;
            updown_reg <= updown_next;
            set_reg    <= (state_next != ST_RUN);
            load_reg   <= (state_next == ST_COMMIT);
            // EDIT_H/M/S encode as 1/2/3; RUN and COMMIT have zero low bits.
            sethms_reg <= state_next[1:0];
        end
    end

    assign set     = set_reg;
    assign load    = load_reg;
    assign hourOut = hour_reg;
    assign minOut  = min_reg;
    assign secOut  = sec_reg;
    assign sethms  = sethms_reg;
    assign upDown  = updown_reg;
endmodule

// File: tb/tb_time_set_controller.sv
// Bench for time_set_controller: sliding-window debounce model plus edit-state model,
// checked every cycle, with directed literal checks and a randomized button phase.
`timescale 1ns/1ps
module tb_time_set_controller;
    localparam int D = 4;
    localparam int R = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] button;
    logic [4:0] hourIn;
    logic [5:0] minIn, secIn;
    logic       set, load, upDown;
    logic [4:0] hourOut;
    logic [5:0] minOut, secOut;
    logic [1:0] sethms;

    time_set_controller #(.DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(R)) dut (
        .clk(clk), .rst(rst), .button(button),
        .hourIn(hourIn), .minIn(minIn), .secIn(secIn),
        .set(set), .load(load), .hourOut(hourOut), .minOut(minOut), .secOut(secOut),
        .sethms(sethms), .upDown(upDown)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Model: st 0=run, 1..3 = editing hour/min/sec, 4 = commit.
    int          m_st, m_h, m_m, m_s, m_rep;
    bit          m_ud;
    logic [3:0]  m_lev, m_pend, m_d1, m_d2;
    logic [31:0] m_hist [4];
    int          m_fill [4];

    int   load_count = 0, load_run = 0, load_run_max = 0;
    int   load_h = 0, load_m = 0, load_s = 0;
    bit   prev_load = 0;
    logic after_load_set = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic [3:0] btn, input int hi, input int mi, input int si);
        logic [31:0] mask;
        logic [3:0]  pend_new;
        bit          up, dn;
        int          rep_prev;
        mask = (32'd1 << D) - 32'd1;
        if (r) begin
            m_st = 0; m_h = 0; m_m = 0; m_s = 0; m_ud = 1; m_rep = 0;
            m_lev = '0; m_pend = '0; m_d1 = '0; m_d2 = '0;
            for (int b = 0; b < 4; b++) begin m_hist[b] = '0; m_fill[b] = 0; end
            return;
        end
        rep_prev = m_rep;
        m_rep = 0;
        if (m_st == 0) begin
            if (m_pend[0]) begin
                m_st = 1;
                m_h = (hi > 23) ? 0 : hi;
                m_m = (mi > 59) ? 0 : mi;
                m_s = (si > 59) ? 0 : si;
            end
        end else if (m_st == 4) begin
            m_st = 0;
        end else if (m_pend[0]) begin
            m_st = 4;
        end else if (m_pend[1]) begin
            m_st = m_st % 3 + 1;
        end else begin
            up = m_pend[2] && !m_pend[3];
            dn = m_pend[3] && !m_pend[2];
`ifdef TIME_SET_AUTOREPEAT_EN
            if (m_pend == 4'd0 && (m_lev[2] != m_lev[3])) begin
                m_rep = rep_prev + 1;
                if (m_rep == R) begin
                    m_rep = 0;
                    up = m_lev[2];
                    dn = m_lev[3];
                end
            end
`endif
            if (up || dn) begin
                m_ud = up;
                case (m_st)
                    1: m_h = up ? (m_h + 1) % 24 : (m_h + 23) % 24;
                    2: m_m = up ? (m_m + 1) % 60 : (m_m + 59) % 60;
                    default: m_s = up ? (m_s + 1) % 60 : (m_s + 59) % 60;
                endcase
            end
        end
        // Debounce: level follows once the last D delayed samples all disagree with it.
        for (int b = 0; b < 4; b++) begin
            m_hist[b] = {m_hist[b][30:0], m_d2[b]};
            if (m_fill[b] < 32) m_fill[b]++;
            pend_new[b] = 1'b0;
            if (m_fill[b] >= D && ((m_hist[b] & mask) == (m_lev[b] ? 32'd0 : mask))) begin
                m_lev[b]    = ~m_lev[b];
                pend_new[b] = m_lev[b];
            end
        end
        m_pend = pend_new;
        m_d2   = m_d1;
        m_d1   = ~btn;
    endtask

    always @(posedge clk) begin
        #2;
        model_step(rst, button, int'(hourIn), int'(minIn), int'(secIn));
        chk("set", set, (m_st != 0));
        chk("load", load, (m_st == 4));
        chk("sethms", sethms, (m_st >= 1 && m_st <= 3) ? m_st : 0);
        chk("upDown", upDown, m_ud);
        chk("hourOut", hourOut, m_h);
        chk("minOut", minOut, m_m);
        chk("secOut", secOut, m_s);
        if (prev_load) after_load_set = set;
        if (load === 1'b1) begin
            load_count++;
            load_run++;
            load_h = hourOut; load_m = minOut; load_s = secOut;
        end else begin
            load_run = 0;
        end
        if (load_run > load_run_max) load_run_max = load_run;
        prev_load = (load === 1'b1);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [3:0] mask, input string what);
        $display("[TB] press %s (mask %b) h/m/s in=%0d/%0d/%0d", what, mask, hourIn, minIn, secIn);
        button = 4'hF & ~mask;
        cyc(D + 6);
        button = 4'hF;
        cyc(D + 6);
    endtask

    task automatic do_reset(input int n);
        $display("[TB] reset for %0d cycles", n);
        rst = 1'b1;
        cyc(n);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; button = 4'hF; hourIn = 5'd23; minIn = 6'd59; secIn = 6'd58;
        cyc(3);
        rst = 1'b0;
        cyc(20);
        chk("lit_reset_set", set, 0);
        chk("lit_reset_sethms", sethms, 0);
        chk("lit_reset_updown", upDown, 1);
        chk("lit_reset_hour", hourOut, 0);
        chk("lit_reset_loads", load_count, 0);

        press(4'b0001, "mode");
        chk("lit_enter_set", set, 1);
        chk("lit_enter_sethms", sethms, 1);
        chk("lit_cap_hour", hourOut, 23);
        chk("lit_cap_min", minOut, 59);
        chk("lit_cap_sec", secOut, 58);
        press(4'b0100, "up");
        chk("lit_hour_wrap_up", hourOut, 0);
        chk("lit_updown_up", upDown, 1);
        press(4'b0010, "field");
        chk("lit_sethms_m", sethms, 2);
        press(4'b0100, "up");
        chk("lit_min_wrap_up", minOut, 0);
        press(4'b1000, "down");
        chk("lit_min_wrap_dn", minOut, 59);
        chk("lit_updown_dn", upDown, 0);
        press(4'b0010, "field");
        chk("lit_sethms_s", sethms, 3);
        press(4'b0010, "field");
        chk("lit_sethms_h", sethms, 1);
        press(4'b0001, "mode");
        chk("lit_commit1_count", load_count, 1);
        chk("lit_commit1_min", load_m, 59);
        chk("lit_commit1_set", set, 0);

        hourIn = 5'd12; minIn = 6'd34; secIn = 6'd56;
        press(4'b0001, "mode");
        chk("lit_cap2_hour", hourOut, 12);
        press(4'b0001, "mode");
        chk("lit_commit2_count", load_count, 2);
        chk("lit_commit2_h", load_h, 12);
        chk("lit_commit2_m", load_m, 34);
        chk("lit_commit2_s", load_s, 56);
        chk("lit_load_width", load_run_max, 1);
        chk("lit_set_after_load", after_load_set, 0);

        $display("[TB] bouncing mode button");
        button = 4'hE; cyc(2); button = 4'hF; cyc(2);
        button = 4'hE; cyc(3); button = 4'hF; cyc(1);
        press(4'b0001, "mode (held after bounce)");
        chk("lit_bounce_set", set, 1);
        chk("lit_bounce_sethms", sethms, 1);

        press(4'b1100, "up+down");
        chk("lit_updn_hour", hourOut, 12);
        chk("lit_updn_dir", upDown, 0);
        press(4'b0100, "up");
        chk("lit_pre_rst_hour", hourOut, 13);
        do_reset(2);
        cyc(3);
        chk("lit_rst_set", set, 0);
        chk("lit_rst_hour", hourOut, 0);
        chk("lit_rst_loads", load_count, 2);

        press(4'b0001, "mode");
        $display("[TB] hold up for 31 cycles");
        button = 4'hB; cyc(31); button = 4'hF; cyc(D + 10);
`ifdef TIME_SET_AUTOREPEAT_EN
        chk("lit_hold_hour", hourOut, 16);
`else
        chk("lit_hold_hour", hourOut, 13);
`endif
        press(4'b0001, "mode");
        chk("lit_commit3_count", load_count, 3);

        do_reset(2);
        for (int seg = 0; seg < 300; seg++) begin
            int sel, len;
            logic [3:0] mask;
            if ($urandom_range(0, 99) < 2) begin
                do_reset(1);
            end
            if ($urandom_range(0, 9) == 0) begin
                hourIn = 5'($urandom_range(0, 31));
                minIn  = 6'($urandom_range(0, 63));
                secIn  = 6'($urandom_range(0, 63));
            end
            sel = $urandom_range(0, 9);
            if (sel < 3)      mask = 4'b0000;
            else if (sel < 8) mask = 4'b0001 << $urandom_range(0, 3);
            else              mask = 4'($urandom_range(0, 15));
            len = $urandom_range(1, 14);
            $display("[TB] random seg %0d mask %b len %0d", seg, mask, len);
            button = 4'hF & ~mask;
            cyc(len);
        end
        button = 4'hF;
        cyc(20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/time_set_controller.md
# time_set_controller

User-input front end for the Cyclone V GX starter-kit clock: debounces the four raw push-buttons, runs the time-editing state machine and drives the edited hour/minute/second value plus a load strobe back into the `clock` counter. It is the input-side counterpart to the display path: the display chain reads the time out to the seven-segment digits, and this block writes user-chosen time into the counter. It also drives the `set`/`sethms`/`upDown` status consumed by the LED indicator logic.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 50000: consecutive stable cycles required to accept a button level change (1 ms at 50 MHz).
- `REPEAT_CYCLES`, 12500000: hold time between auto-repeat steps; used only with `TIME_SET_AUTOREPEAT_EN`.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset, synchronous and active-high.
- `button`  in  4  raw KEY inputs, active-low, asynchronous: [0] mode, [1] field select, [2] up, [3] down.
- `hourIn`  in  5  current hour from `clock`, 0..23.
- `minIn`  in  6  current minute, 0..59.
- `secIn`  in  6  current second, 0..59.
- `set`  out  1  high while editing; `clock` halts counting.
- `load`  out  1  one-cycle strobe; `clock` copies the `*Out` values.
- `hourOut`  out  5  edited hour.
- `minOut`  out  6  edited minute.
- `secOut`  out  6  edited second.
- `sethms`  out  2  selected field: 0 none, 1 hour, 2 minute, 3 second.
- `upDown`  out  1  direction of the last step: 1 up, 0 down.

## Operation
- Per button: a 2-flop synchronizer, then a debouncer. The debounced level flips after the synchronized level differs from it for `DEBOUNCE_CYCLES` consecutive cycles. Any bounce restarts the count.
- A press event is a one-cycle pulse when the debounced level goes released→pressed. Releases generate no event.
- FSM states and transitions:
  - RUN → EDIT_H on mode press. Capture `hourIn/minIn/secIn` into the shadow registers `hourOut/minOut/secOut`.
  - EDIT_H → EDIT_M → EDIT_S → EDIT_H on field press.
  - Any EDIT state → COMMIT on mode press.
  - COMMIT → RUN unconditionally after one cycle.
- `set` = 1 in every EDIT state and in COMMIT; `set` = 0 in RUN.
- `sethms` reports 1/2/3 in EDIT_H/M/S; 0 in RUN and in COMMIT.
- `load` = 1 only in the COMMIT cycle.
- In an EDIT state, an up press increments the selected field and a down press decrements it. Each step sets `upDown`.
- Wrap-around:
  - hour: 23 +1 → 0, 0 −1 → 23.
  - minute and second: 59 +1 → 0, 0 −1 → 59.
  - Out-of-range captured input (hour > 23 or min/sec > 59) is clamped to 0 at capture.
- Simultaneous events in one cycle:
  - up and down together: both ignored.
  - mode with any other event: mode wins, others dropped.
  - field with up/down: field change applied, step dropped.
- Up/down/field presses in RUN are ignored. Shadow registers then hold their last value.
- `rst` mid-edit abandons the edit: no `load`, and edited values are lost.

## Timing
- Reset values: `set`=0, `load`=0, `sethms`=0, `upDown`=1, `hourOut`=`minOut`=`secOut`=0, state RUN, all debounced levels released, all counters 0.
- Latency from a raw `button` edge (held stable) to the press pulse: 2 sync cycles + `DEBOUNCE_CYCLES` + 1 cycle.
- Registers and outputs update on the cycle after the pulse: state, shadow, `set`, `sethms`, `upDown`.
- `load` rises the cycle after the commit-causing mode pulse and lasts exactly one cycle. `set` falls the cycle after `load`.
- `*Out` values are stable throughout the `load` cycle.
- All outputs are registered; there are no combinational paths from inputs.

## Configuration
- `TIME_SET_AUTOREPEAT_EN` defined:
  - While up or down stays debounced-pressed in an EDIT state, an extra step fires every `REPEAT_CYCLES` cycles, with the first repeat `REPEAT_CYCLES` after the press pulse.
  - A field change, mode press or release resets the repeat counter.
- Undefined: one step per press only, and no repeat counter is synthesized.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `REPEAT_CYCLES`=8.
- Reset, all buttons released for 20 cycles → all outputs at reset values; `load` never asserts.
- `hourIn`=23/`minIn`=59/`secIn`=58; press mode → `set`=1, `sethms`=1, outputs 23/59/58. Then up → `hourOut`=0, `upDown`=1.
- In EDIT_M with `minOut`=0: press down → 59, `upDown`=0. Field twice → `sethms` 3 then 1.
- Bounce mode as 0,1,0,1 (each ≤3 cycles) then hold 0 → exactly one press pulse, one transition.
- Edit to 12/34/56, then press mode → `load` high for exactly one cycle with outputs 12/34/56; `set`=0 the following cycle.
- Up and down pressed in the same cycle → no change. `rst` asserted mid-edit → RUN, `set`=0, no `load`. With `TIME_SET_AUTOREPEAT_EN`, hold up 30 cycles past the pulse → 1+3 steps.
